// File: rtl/uart_disp_pkg.sv
// Shared definitions for the UART-fed 7-segment display scan controller.
// Holds the scan state encoding, the control-character codes that drive
// buffer editing, and a helper that classifies printable bytes.
package uart_disp_pkg;

  typedef enum logic {
    GAP = 1'b0,
    ON  = 1'b1
  } scan_state_t;

  localparam logic [7:0] ASCII_BS        = 8'h08;
  localparam logic [7:0] ASCII_DEL       = 8'h7F;
  localparam logic [7:0] ASCII_CR        = 8'h0D;
  localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
  localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_PRINT_MIN) && (b <= ASCII_PRINT_MAX);
  endfunction

  function automatic logic is_erase(input logic [7:0] b);
    return (b == ASCII_BS) || (b == ASCII_DEL);
  endfunction

endpackage

// File: rtl/disp_scan_timer.sv
// Round-robin digit scan timer. Each digit slot lasts SCAN_DIV cycles: the
// first GAP_CYCLES with every digit dark, the rest with the digit lit.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   idx         digit currently being scanned (0..NUM_DIGITS-1)
//   in_gap      high while the slot is in its blank gap
//   gap_end     pulse on the last gap cycle (next edge enters ON)
//   slot_end    pulse on the last cycle of the slot (next edge enters GAP)
module disp_scan_timer
  import uart_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GAP_CYCLES = 500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [$clog2(NUM_DIGITS)-1:0] idx,
  output logic                          in_gap,
  output logic                          gap_end,
  output logic                          slot_end
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  scan_state_t      state;
  scan_state_t      state_next;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= GAP;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      GAP:     if (cnt == GAP_LAST)  state_next = ON;
      ON:      if (cnt == SLOT_LAST) state_next = GAP;
      default: state_next = GAP;
    endcase
  end

  always_comb begin
    in_gap   = (state == GAP);
    gap_end  = (state == GAP) && (cnt == GAP_LAST);
    slot_end = (state == ON)  && (cnt == SLOT_LAST);
  end

  // cnt runs across the whole slot (gap and on-time), so the slot period
  // is fixed at SCAN_DIV regardless of what the buffer does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_disp_scan_ctrl.sv
// Character buffer and scan output stage for a row of common-anode 7-segment
// digits sharing one external ASCII decoder. Printable UART bytes shift in at
// the rightmost digit; BS/DEL erase the newest character; CR or clear empty
// the buffer. The scan timer walks the digits, and this block presents the
// selected character to the decoder and enables the matching digit.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   rx_data      byte from the UART receiver
//   rx_valid     one-cycle strobe qualifying rx_data
//   clear        synchronous buffer clear (level)
//   ascii_out    registered character to the shared decoder
//   digit_en_n   registered active-low digit enables, one-hot-low or all high
//   char_count   number of occupied buffer slots
module uart_disp_scan_ctrl
  import uart_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GAP_CYCLES = 500
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  input  logic                            clear,
  output logic [7:0]                      ascii_out,
  output logic [NUM_DIGITS-1:0]           digit_en_n,
  output logic [$clog2(NUM_DIGITS+1)-1:0] char_count
);

  localparam int CC_W  = $clog2(NUM_DIGITS + 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CC_W-1:0]       CC_FULL = CC_W'(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] DIG0    = NUM_DIGITS'(1);

  logic [NUM_DIGITS-1:0] slot_vld;
  logic [7:0]            slot_chr [NUM_DIGITS];

  logic [IDX_W-1:0] idx;
  logic             in_gap;
  logic             gap_end;
  logic             slot_end;

  logic do_clear;
  logic do_push;
  logic do_pop;

  disp_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx      (idx),
    .in_gap   (in_gap),
    .gap_end  (gap_end),
    .slot_end (slot_end)
  );

  // clear dominates a same-cycle byte; the three edits are mutually exclusive.
  always_comb begin
    do_clear = clear || (rx_valid && (rx_data == ASCII_CR));
    do_push  = !clear && rx_valid && is_printable(rx_data);
    do_pop   = !clear && rx_valid && is_erase(rx_data) && (char_count != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld   <= '0;
      char_count <= '0;
    end else if (do_clear) begin
      slot_vld   <= '0;
      char_count <= '0;
    end else if (do_push) begin
      slot_vld   <= {slot_vld[NUM_DIGITS-2:0], 1'b1};
      char_count <= (char_count == CC_FULL) ? char_count : char_count + CC_W'(1);
    end else if (do_pop) begin
      slot_vld   <= {1'b0, slot_vld[NUM_DIGITS-1:1]};
      char_count <= char_count - CC_W'(1);
    end
  end

  // Character storage needs no reset: an invalid slot is never displayed
  // and reads back as 8'h00 through the output mux below.
  always_ff @(posedge clk) begin
    if (do_push) begin
      slot_chr[0] <= rx_data;
      for (int k = 1; k < NUM_DIGITS; k++) slot_chr[k] <= slot_chr[k-1];
    end else if (do_pop) begin
      for (int k = 0; k < NUM_DIGITS - 1; k++) slot_chr[k] <= slot_chr[k+1];
    end
  end

  // ascii_out only moves during the gap, and the digit's valid bit is
  // captured on the same edge that makes the final gap load, so character
  // and enable always agree and nothing changes while a digit is lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ascii_out  <= 8'h00;
      digit_en_n <= '1;
    end else begin
      if (in_gap) ascii_out <= slot_vld[idx] ? slot_chr[idx] : 8'h00;
      if (gap_end)       digit_en_n <= slot_vld[idx] ? ~(DIG0 << idx) : '1;
      else if (slot_end) digit_en_n <= '1;
    end
  end

endmodule

// File: tb/tb_uart_disp_scan_ctrl.sv
// Directed bench for uart_disp_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8,
// GAP_CYCLES=2. A bench-side edge counter since reset release gives the
// expected scan phase: frame position = edges % 32, idx = pos / 8,
// cnt = pos % 8, digit lit for cnt 2..7.
module tb_uart_disp_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       clear;
  logic [7:0] ascii_out;
  logic [3:0] digit_en_n;
  logic [2:0] char_count;

  int n_cmp;
  int n_bad;
  int edges;

  uart_disp_scan_ctrl #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (8),
    .GAP_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .clear      (clear),
    .ascii_out  (ascii_out),
    .digit_en_n (digit_en_n),
    .char_count (char_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic goto_phase(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((edges % 32) != target) && (n < 80));
    if (n >= 80) chk("goto_phase_timeout", 32'd1, 32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // chars: byte k is the expected character for idx k; lit: which idx light.
  task automatic check_frame(input string tag, input logic [31:0] chars, input logic [3:0] lit);
    logic [3:0] one;
    logic [3:0] exp_en;
    int         bad;
    one = 4'b0001;
    goto_phase(0);
    for (int s = 0; s < 4; s++) begin
      bad = 0;
      for (int c = 0; c < 8; c++) begin
        if (c > 0 || s > 0) @(negedge clk);
        exp_en = (c >= 2 && lit[s]) ? ~(one << s) : 4'hF;
        if (digit_en_n !== exp_en) bad++;
        if (c >= 2 && lit[s] && ascii_out !== chars[s*8 +: 8]) bad++;
        if (c == 2) chk($sformatf("%s_en_idx%0d", tag, s), {28'd0, digit_en_n}, {28'd0, exp_en});
        if (c == 2 && lit[s]) chk($sformatf("%s_chr_idx%0d", tag, s), {24'd0, ascii_out}, {24'd0, chars[s*8 +: 8]});
      end
      chk($sformatf("%s_slot%0d_bad_cycles", tag, s), bad, 0);
    end
  endtask

  initial begin
    int bad;
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    clear    = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_en", {28'd0, digit_en_n}, 32'hF);
    chk("rst_count", {29'd0, char_count}, 32'd0);
    chk("rst_ascii", {24'd0, ascii_out}, 32'h00);
    rst_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (digit_en_n !== 4'hF || ascii_out !== 8'h00 || char_count !== 3'd0) bad++;
    end
    chk("idle_64_bad_cycles", bad, 0);

    send("1"); send("2"); send("3");
    chk("cnt_after_123", {29'd0, char_count}, 32'd3);
    check_frame("f123", {8'h00, 8'h31, 8'h32, 8'h33}, 4'b0111);

    send(8'h0D);
    chk("cnt_after_cr", {29'd0, char_count}, 32'd0);
    send("A"); send("B"); send("C"); send("D"); send("E");
    chk("cnt_after_ABCDE", {29'd0, char_count}, 32'd4);
    check_frame("fABCDE", {8'h42, 8'h43, 8'h44, 8'h45}, 4'b1111);

    send(8'h0D);
    send("1"); send("2"); send("3");
    send(8'h08);
    chk("cnt_after_bs1", {29'd0, char_count}, 32'd2);
    check_frame("fbs", {8'h00, 8'h00, 8'h31, 8'h32}, 4'b0011);
    send(8'h08);
    chk("cnt_after_bs2", {29'd0, char_count}, 32'd1);
    send(8'h08);
    chk("cnt_after_bs3", {29'd0, char_count}, 32'd0);
    send(8'h08);
    chk("cnt_bs_underflow", {29'd0, char_count}, 32'd0);
    check_frame("fempty", 32'd0, 4'b0000);

    send("1"); send("2"); send(8'h7F);
    chk("cnt_after_del", {29'd0, char_count}, 32'd1);
    check_frame("fdel", {8'h00, 8'h00, 8'h00, 8'h31}, 4'b0001);

    send("7"); send("8");
    chk("cnt_before_clear", {29'd0, char_count}, 32'd3);
    clear    = 1'b1;
    rx_data  = "9";
    rx_valid = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    rx_valid = 1'b0;
    chk("cnt_after_clear", {29'd0, char_count}, 32'd0);
    send("5");
    chk("cnt_after_5", {29'd0, char_count}, 32'd1);
    send(8'h0A); send(8'hC5);
    chk("cnt_after_ignored", {29'd0, char_count}, 32'd1);
    check_frame("fign", {8'h00, 8'h00, 8'h00, 8'h35}, 4'b0001);

    send(8'h0D);
    send("1"); send("2"); send("3");
    goto_phase(0);
    goto_phase(20);
    chk("mid_on_idx2_en", {28'd0, digit_en_n}, 32'hB);
    rst_n = 1'b0;
    #1;
    chk("async_rst_en", {28'd0, digit_en_n}, 32'hF);
    chk("async_rst_count", {29'd0, char_count}, 32'd0);
    chk("async_rst_ascii", {24'd0, ascii_out}, 32'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_first_edge_en", {28'd0, digit_en_n}, 32'hF);
    send("4");
    goto_phase(2);
    chk("restart_idx0_en", {28'd0, digit_en_n}, 32'hE);
    chk("restart_idx0_chr", {24'd0, ascii_out}, 32'h34);
    goto_phase(10);
    chk("restart_idx1_dark", {28'd0, digit_en_n}, 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
